// File: rtl/bin_to_bcd.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Optional two's-complement input: the magnitude is converted and the sign reported separately.
module bin_to_bcd #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
) (
  input  logic                  uclk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      in_value,
  input  logic                  in_signed,
  input  logic                  in_vld,
  output logic                  in_rdy,
  output logic                  busy,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_neg,
  output logic [3:0]            out_ndigits,
  output logic                  out_vld,
  output logic [1:0]            dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Handshake: a request is taken on a rising edge where in_vld && in_rdy;
  // in_rdy is high only in IDLE, so requests during SHIFT/DONE are dropped, not queued.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state, state_next;
  logic [WIDTH-1:0]     mag;
  logic [4*DIGITS-1:0]  bcd;
  logic [4*DIGITS-1:0]  bcd_adj;
  logic [CW-1:0]        cnt;
  logic                 sign;
  logic                 accept;
  logic                 in_neg;
  logic [WIDTH-1:0]     in_mag;
  logic [3:0]           ndigits;

  assign in_rdy    = (state == IDLE);
  assign busy      = (state != IDLE);
  assign dbg_state = state;
  assign accept    = in_vld && (state == IDLE);
  assign in_neg    = in_signed & in_value[WIDTH-1];
  // The most negative value negates to itself, which read as unsigned is the correct magnitude.
  assign in_mag    = in_neg ? (~in_value + WIDTH'(1)) : in_value;

  always_ff @(posedge uclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = SHIFT;
      SHIFT:   if (cnt == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    ndigits = 4'd1;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] != 4'd0) ndigits = 4'(i + 1);
    end
  end

  always_ff @(posedge uclk or negedge rst_n) begin
    if (!rst_n) begin
      mag         <= '0;
      bcd         <= '0;
      cnt         <= '0;
      sign        <= 1'b0;
      out_bcd     <= '0;
      out_neg     <= 1'b0;
      out_ndigits <= 4'd0;
      out_vld     <= 1'b0;
    end else begin
      out_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            sign <= in_neg;
            mag  <= in_mag;
            bcd  <= '0;
            cnt  <= CW'(WIDTH - 1);
          end
        end
        SHIFT: begin
          bcd <= {bcd_adj[4*DIGITS-2:0], mag[WIDTH-1]};
          mag <= {mag[WIDTH-2:0], 1'b0};
          cnt <= cnt - CW'(1);
        end
        DONE: begin
          out_bcd     <= bcd;
          out_neg     <= sign;
          out_ndigits <= ndigits;
          out_vld     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd.sv
// Directed bench for bin_to_bcd: hand-computed BCD results, latency, handshake and reset abort.
module tb_bin_to_bcd;

  logic        uclk;
  logic        rst_n;
  logic [31:0] in_value;
  logic        in_signed;
  logic        in_vld;
  logic        in_rdy;
  logic        busy;
  logic [39:0] out_bcd;
  logic        out_neg;
  logic [3:0]  out_ndigits;
  logic        out_vld;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  bin_to_bcd #(.WIDTH(32), .DIGITS(10)) dut (
    .uclk        (uclk),
    .rst_n       (rst_n),
    .in_value    (in_value),
    .in_signed   (in_signed),
    .in_vld      (in_vld),
    .in_rdy      (in_rdy),
    .busy        (busy),
    .out_bcd     (out_bcd),
    .out_neg     (out_neg),
    .out_ndigits (out_ndigits),
    .out_vld     (out_vld),
    .dbg_state   (dbg_state)
  );

  initial uclk = 1'b0;
  always #5 uclk = ~uclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Issues one request and returns the number of edges from accept to out_vld.
  task automatic convert(input logic [31:0] v, input logic s, output int lat);
    @(negedge uclk);
    in_value  = v;
    in_signed = s;
    in_vld    = 1'b1;
    @(posedge uclk); #1;
    in_vld    = 1'b0;
    in_value  = $urandom;
    in_signed = 1'($urandom_range(0, 1));
    lat = 0;
    while (!out_vld && lat < 60) begin
      @(posedge uclk); #1;
      lat++;
    end
  endtask

  task automatic expect_result(input string tag, input logic [31:0] v, input logic s,
                               input logic [39:0] bcd, input logic neg, input logic [3:0] nd);
    int lat;
    convert(v, s, lat);
    check({tag, "_lat"}, 64'(lat), 64'd33);
    check({tag, "_bcd"}, 64'(out_bcd), 64'(bcd));
    check({tag, "_neg"}, 64'(out_neg), 64'(neg));
    check({tag, "_nd"},  64'(out_ndigits), 64'(nd));
    @(posedge uclk); #1;
    check({tag, "_pulse"}, 64'(out_vld), 64'd0);
  endtask

  initial begin
    int lat;
    int gap;
    int pulses;
    rst_n = 1'b0; in_value = '0; in_signed = 1'b0; in_vld = 1'b0;
    repeat (2) @(posedge uclk);
    #1;
    check("rst_bcd", 64'(out_bcd), 64'd0);
    check("rst_nd",  64'(out_ndigits), 64'd0);
    check("rst_vld", 64'(out_vld), 64'd0);
    check("rst_rdy", 64'(in_rdy), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    @(negedge uclk); rst_n = 1'b1;

    // busy/in_rdy/state right after an accept
    @(negedge uclk); in_value = 32'd255; in_signed = 1'b0; in_vld = 1'b1;
    @(posedge uclk); #1; in_vld = 1'b0;
    check("acc_busy",  64'(busy), 64'd1);
    check("acc_rdy",   64'(in_rdy), 64'd0);
    check("acc_state", 64'(dbg_state), 64'd1);
    lat = 0;
    while (!out_vld && lat < 60) begin @(posedge uclk); #1; lat++; end
    check("u255_lat", 64'(lat), 64'd33);
    check("u255_bcd", 64'(out_bcd), 64'h255);
    check("u255_nd",  64'(out_ndigits), 64'd3);

    expect_result("s_m1",   32'hFFFF_FFFF, 1'b1, 40'h1,          1'b1, 4'd1);
    expect_result("u_max",  32'hFFFF_FFFF, 1'b0, 40'h4294967295, 1'b0, 4'd10);
    expect_result("s_min",  32'h8000_0000, 1'b1, 40'h2147483648, 1'b1, 4'd10);
    expect_result("s_zero", 32'd0,         1'b1, 40'h0,          1'b0, 4'd1);
    expect_result("u_1000", 32'd1000,      1'b0, 40'h1000,       1'b0, 4'd4);

    // in_vld held high: 12 accepted, 34 waits for IDLE
    @(negedge uclk); in_value = 32'd12; in_signed = 1'b0; in_vld = 1'b1;
    @(posedge uclk); #1; in_value = 32'd34;
    lat = 0;
    while (!out_vld && lat < 60) begin @(posedge uclk); #1; lat++; end
    check("hold_lat1", 64'(lat), 64'd33);
    check("hold_bcd1", 64'(out_bcd), 64'h12);
    gap = 0;
    @(posedge uclk); #1; gap++;
    check("hold_busy2", 64'(busy), 64'd1);
    repeat (5) begin @(posedge uclk); #1; gap++; end
    check("hold_keep", 64'(out_bcd), 64'h12);
    in_vld = 1'b0;
    while (!out_vld && gap < 80) begin @(posedge uclk); #1; gap++; end
    check("hold_gap",  64'(gap), 64'd34);
    check("hold_bcd2", 64'(out_bcd), 64'h34);

    // reset mid-conversion of 999
    @(posedge uclk); #1;
    convert_start: begin
      @(negedge uclk); in_value = 32'd999; in_signed = 1'b0; in_vld = 1'b1;
      @(posedge uclk); #1; in_vld = 1'b0;
    end
    repeat (10) @(posedge uclk);
    #1; rst_n = 1'b0; #1;
    check("abort_bcd",  64'(out_bcd), 64'd0);
    check("abort_nd",   64'(out_ndigits), 64'd0);
    check("abort_rdy",  64'(in_rdy), 64'd1);
    check("abort_busy", 64'(busy), 64'd0);
    @(negedge uclk); rst_n = 1'b1;
    pulses = 0;
    repeat (40) begin @(posedge uclk); #1; if (out_vld) pulses++; end
    check("abort_novld", 64'(pulses), 64'd0);
    expect_result("post_7", 32'd7, 1'b0, 40'h7, 1'b0, 4'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
